// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences a single-ported, fixed-latency unified memory that is shared by
//   instruction fetch and data load/store. Only one access is in flight at a
//   time. Data has fixed priority over fetch. The block counts out MEM_LAT
//   cycles and then pulses the owner's done. HLT parks the block in HALTED,
//   and only reset leaves that state.
// Ports
//   clk, rst_n                          clock, async active-low reset
//   if_req/if_addr -> if_rdata/if_done  fetch port (req held until done)
//   dm_req/dm_we/dm_addr/dm_wdata
//     -> dm_rdata/dm_done               data port (req held until done)
//   hlt                                 halt request
//   mem_en/mem_we/mem_addr/mem_wdata    memory issue, one strobe per access
//   mem_rdata                           memory read data, MEM_LAT after issue
//   stall, halted                       CPU stall and halt status
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  input  logic              hlt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              halted
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, HALTED} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          hlt_pend, hlt_pend_nx;   // hlt seen since the current issue
  logic          st_we, st_we_nx;         // current data access is a store
  logic          issue, issue_dm;
  logic          last;

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hlt_pend <= 1'b0;
      st_we    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      hlt_pend <= hlt_pend_nx;
      st_we    <= st_we_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hlt_pend_nx = hlt_pend;
    st_we_nx    = st_we;
    issue       = 1'b0;
    issue_dm    = 1'b0;
    // The issue strobe is combinational in IDLE. Holding it off while reset
    // is asserted keeps every output at 0 while a requester keeps req high.
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (hlt) begin
            state_nx = HALTED;
          end else if (dm_req) begin
            issue       = 1'b1;
            issue_dm    = 1'b1;
            state_nx    = BUSY_DM;
            cnt_nx      = CW'(MEM_LAT);
            st_we_nx    = dm_we;
            hlt_pend_nx = 1'b0;
          end else if (if_req) begin
            issue       = 1'b1;
            state_nx    = BUSY_IF;
            cnt_nx      = CW'(MEM_LAT);
            st_we_nx    = 1'b0;
            hlt_pend_nx = 1'b0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          cnt_nx      = cnt - CW'(1);
          hlt_pend_nx = hlt_pend | hlt;
          // An access cannot be aborted. hlt only decides where the block
          // goes after the done cycle.
          if (last) state_nx = (hlt_pend | hlt) ? HALTED : IDLE;
        end
        default: ;  // HALTED is absorbing
      endcase
    end
  end

  assign mem_en    = issue;
  assign mem_we    = issue_dm & dm_we;
  assign mem_addr  = !issue ? '0 : (issue_dm ? dm_addr : if_addr);
  assign mem_wdata = (issue_dm & dm_we) ? dm_wdata : '0;

  assign if_done  = (state == BUSY_IF) & last;
  assign dm_done  = (state == BUSY_DM) & last;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign dm_rdata = (dm_done & ~st_we) ? mem_rdata : '0;

  assign stall  = rst_n & ((if_req & ~if_done) | (dm_req & ~dm_done));
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. Instance "a" uses MEM_LAT=4 and
//   instance "b" uses MEM_LAT=1. Directed stimulus pushes the expected issues
//   and completions into queues. Per-instance monitors pop those queues and
//   compare whenever the DUT strobes mem_en or a done.
module tb_mem_port_arbiter;
  localparam int LAT  = 4;
  localparam int LATB = 1;

  typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata;} iss_t;
  typedef struct {logic dm; logic [15:0] data;} dn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5D3;
  endfunction

  // ---------------- instance a (MEM_LAT=4) ----------------
  logic        if_req = 0, dm_req = 0, dm_we = 0, hlt = 0;
  logic [15:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, dm_done, mem_en, mem_we, stall, halted;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .hlt(hlt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .halted(halted));

  // Memory model: read data appears LAT cycles after the issue cycle.
  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_en ? mdata(mem_addr) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  iss_t iss_q[$];
  dn_t  dn_q[$];
  int   icyc[$];
  int   last_iss = 0;
  iss_t ie;
  dn_t  de;

  always @(negedge clk) if (rst_n) begin
    if (mem_en) begin
      icyc.push_back(cyc);
      last_iss = cyc;
      if (iss_q.size() == 0) chk("a_unexpected_issue", mem_en, 0);
      else begin
        ie = iss_q.pop_front();
        chk("a_mem_we", mem_we, ie.we);
        chk("a_mem_addr", mem_addr, ie.addr);
        if (ie.we) chk("a_mem_wdata", mem_wdata, ie.wdata);
      end
    end
    if (if_done | dm_done) begin
      if (dn_q.size() == 0) chk("a_unexpected_done", if_done | dm_done, 0);
      else begin
        de = dn_q.pop_front();
        chk("a_done_port", {if_done, dm_done}, {~de.dm, de.dm});
        chk("a_rdata", de.dm ? dm_rdata : if_rdata, de.data);
        chk("a_done_latency", cyc - last_iss, LAT);
      end
    end
  end

  // ---------------- instance b (MEM_LAT=1) ----------------
  logic        b_if_req = 0, b_dm_req = 0, b_dm_we = 0, b_hlt = 0;
  logic [15:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0;
  logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_done, b_dm_done, b_mem_en, b_mem_we, b_stall, b_halted;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LATB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_done(b_dm_done), .hlt(b_hlt),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall(b_stall), .halted(b_halted));

  always @(posedge clk) b_mem_rdata <= b_mem_en ? mdata(b_mem_addr) : 16'hDEAD;

  iss_t b_iss_q[$];
  dn_t  b_dn_q[$];
  int   b_icyc[$];
  int   b_last_iss = 0;
  iss_t bie;
  dn_t  bde;

  always @(negedge clk) if (rst_n) begin
    if (b_mem_en) begin
      b_icyc.push_back(cyc);
      b_last_iss = cyc;
      if (b_iss_q.size() == 0) chk("b_unexpected_issue", b_mem_en, 0);
      else begin
        bie = b_iss_q.pop_front();
        chk("b_mem_we", b_mem_we, bie.we);
        chk("b_mem_addr", b_mem_addr, bie.addr);
      end
    end
    if (b_if_done | b_dm_done) begin
      if (b_dn_q.size() == 0) chk("b_unexpected_done", b_if_done | b_dm_done, 0);
      else begin
        bde = b_dn_q.pop_front();
        chk("b_done_port", {b_if_done, b_dm_done}, {~bde.dm, bde.dm});
        chk("b_rdata", bde.dm ? b_dm_rdata : b_if_rdata, bde.data);
        chk("b_done_latency", cyc - b_last_iss, LATB);
      end
    end
  end

  // ---------------- requester helpers ----------------
  // which: 0 a.if, 1 a.dm, 2 b.if, 3 b.dm. Returns #1 after the edge that
  // samples done, so the caller drops req exactly on that edge.
  function automatic logic done_of(input int which);
    case (which)
      0: return if_done;
      1: return dm_done;
      2: return b_if_done;
      default: return b_dm_done;
    endcase
  endfunction

  task automatic wait_done(input int which);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_of(which) && n < 40);
    if (!done_of(which)) chk($sformatf("done_timeout_%0d", which), 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic req_if(input logic [15:0] a);
    if_addr = a; if_req = 1; wait_done(0); if_req = 0;
  endtask

  task automatic req_dm(input logic we, input logic [15:0] a, input logic [15:0] wd);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1; wait_done(1); dm_req = 0;
  endtask

  task automatic b_seq(input bit dm, input logic [15:0] a0, input logic [15:0] a1);
    for (int k = 0; k < 2; k++) begin
      if (dm) begin b_dm_addr = (k == 0) ? a0 : a1; b_dm_req = 1; end
      else    begin b_if_addr = (k == 0) ? a0 : a1; b_if_req = 1; end
      wait_done(dm ? 3 : 2);
      if (dm) b_dm_req = 0; else b_if_req = 0;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n_en;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctl", {mem_en, mem_we, if_done, dm_done, stall, halted}, 0);
    chk("reset_bus", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", {if_rdata, dm_rdata}, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: single fetch, stall held until done
    iss_q.push_back('{1'b0, 16'h0010, 16'h0000});
    dn_q.push_back('{1'b0, 16'hA5C3});
    fork
      req_if(16'h0010);
      begin
        @(negedge clk); chk("t1_stall_issue", stall, 1);
        repeat (2) @(negedge clk); chk("t1_stall_busy", stall, 1);
      end
    join
    @(negedge clk); chk("t1_stall_after", stall, 0);
    @(posedge clk); #1;

    // 2: simultaneous store and fetch, store first
    iss_q.push_back('{1'b1, 16'h0200, 16'h1234});
    iss_q.push_back('{1'b0, 16'h0020, 16'h0000});
    dn_q.push_back('{1'b1, 16'h0000});
    dn_q.push_back('{1'b0, mdata(16'h0020)});
    fork
      req_dm(1'b1, 16'h0200, 16'h1234);
      req_if(16'h0020);
    join
    chk("t2_spacing", icyc[$] - icyc[$-1], 5);

    // 3: back-to-back loads with dm_req held through dm_done
    iss_q.push_back('{1'b0, 16'h0300, 16'h0000});
    iss_q.push_back('{1'b0, 16'h0302, 16'h0000});
    dn_q.push_back('{1'b1, mdata(16'h0300)});
    dn_q.push_back('{1'b1, mdata(16'h0302)});
    dm_we = 0; dm_addr = 16'h0300; dm_req = 1;
    wait_done(1);
    dm_addr = 16'h0302;
    wait_done(1);
    dm_req = 0;
    chk("t3_spacing", icyc[$] - icyc[$-1], 5);

    // 4: hlt two cycles into a fetch. The fetch completes, then the block halts.
    iss_q.push_back('{1'b0, 16'h0040, 16'h0000});
    dn_q.push_back('{1'b0, mdata(16'h0040)});
    if_addr = 16'h0040; if_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 hlt = 1;
    @(posedge clk); #1 hlt = 0;
    wait_done(0);
    n_en = 0;
    repeat (20) begin @(negedge clk); n_en += mem_en; end
    chk("t4_no_issue", n_en, 0);
    chk("t4_halted", halted, 1);
    chk("t4_stall_held", stall, 1);

    // 5: reset mid-access. Outputs clear at once, and the access is abandoned.
    @(posedge clk); #1 rst_n = 0; if_req = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("t5_unhalted", halted, 0);
    iss_q.push_back('{1'b0, 16'h0050, 16'h0000});
    if_addr = 16'h0050; if_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("t5_rst_ctl", {mem_en, mem_we, if_done, dm_done, stall, halted}, 0);
    chk("t5_rst_bus", {mem_addr, if_rdata, dm_rdata}, 0);
    @(negedge clk); chk("t5_no_done", if_done, 0);
    @(posedge clk); #1;
    iss_q.push_back('{1'b0, 16'h0060, 16'h0000});
    dn_q.push_back('{1'b0, mdata(16'h0060)});
    if_addr = 16'h0060;
    rst_n = 1;
    wait_done(0);
    if_req = 0;

    // 6: MEM_LAT=1 instance, alternating data and fetch
    b_iss_q.push_back('{1'b0, 16'h0070, 16'h0000});
    b_iss_q.push_back('{1'b0, 16'h0080, 16'h0000});
    b_iss_q.push_back('{1'b0, 16'h0072, 16'h0000});
    b_iss_q.push_back('{1'b0, 16'h0082, 16'h0000});
    b_dn_q.push_back('{1'b1, mdata(16'h0070)});
    b_dn_q.push_back('{1'b0, mdata(16'h0080)});
    b_dn_q.push_back('{1'b1, mdata(16'h0072)});
    b_dn_q.push_back('{1'b0, mdata(16'h0082)});
    b_icyc.delete();
    fork
      b_seq(1'b1, 16'h0070, 16'h0072);
      b_seq(1'b0, 16'h0080, 16'h0082);
    join
    chk("t6_issue_count", b_icyc.size(), 4);
    if (b_icyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("t6_spacing", b_icyc[k] - b_icyc[k-1], 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", iss_q.size() + dn_q.size() + b_iss_q.size() + b_dn_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
